// File: rtl/dsp_pipe_pkg.sv
// Shared types and helpers for the elastic DSP pipeline: beat layout, popcount, occupancy width.
`ifndef DSP_PIPE_PKG_SV
`define DSP_PIPE_PKG_SV

`define DSP_PIPE_BEAT_T(W) struct packed { logic valid; logic [(W)-1:0] data; }

package dsp_pipe_pkg;

  localparam int MAX_DEPTH = 16;

  typedef `DSP_PIPE_BEAT_T(18) pipe_beat_t;

  // Number of registered slots in a mask, i.e. the no-stall latency of the chain.
  function automatic int popcount(input logic [MAX_DEPTH-1:0] bits);
    int n;
    n = 0;
    for (int i = 0; i < MAX_DEPTH; i++) n += int'(bits[i]);
    return n;
  endfunction

  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

`endif

// File: rtl/dsp_pipe_slot.sv
// One elastic stage: either a valid/data register that accepts whenever empty or draining,
// or a zero-latency combinational bypass.
module dsp_pipe_slot
  import dsp_pipe_pkg::*;
#(
  parameter type beat_t   = pipe_beat_t,
  parameter bit  BYPASS   = 1'b0,
  parameter bit  RST_DATA = 1'b0
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  ce,
  input  logic  flush,
  input  beat_t up_beat,
  output logic  up_ready,
  output beat_t dn_beat,
  input  logic  dn_ready
`ifdef DSP_PIPE_OCCUPANCY_EN
  ,
  output logic  nxt_valid
`endif
);

  localparam int W = $bits(beat_t) - 1;

  if (BYPASS) begin : g_bypass
    logic unused_ctl;
    assign unused_ctl = ^{clk, rst, ce, flush};
    assign dn_beat    = up_beat;
    assign up_ready   = dn_ready;
`ifdef DSP_PIPE_OCCUPANCY_EN
    assign nxt_valid  = 1'b0;
`endif
  end else begin : g_reg
    logic         v;
    logic         v_nxt;
    logic         load;
    logic [W-1:0] d;

    assign up_ready = ~v | dn_ready;

    always_comb begin
      v_nxt = v;
      if (ce) begin
        if (flush)         v_nxt = 1'b0;
        else if (up_ready) v_nxt = up_beat.valid;
      end
    end

    // Data only moves with a real beat, so idle cycles leave the last value in place.
    assign load = ce & ~flush & up_ready & up_beat.valid & ~rst;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) v <= 1'b0;
      else     v <= v_nxt;
    end

    if (RST_DATA) begin : g_data_rst
      always_ff @(posedge clk or posedge rst) begin
        if (rst)       d <= '0;
        else if (load) d <= up_beat.data;
      end
    end else begin : g_data_norst
      always_ff @(posedge clk) begin
        if (load) d <= up_beat.data;
      end
    end

    always_comb begin
      dn_beat.valid = v;
      dn_beat.data  = d;
    end

`ifdef DSP_PIPE_OCCUPANCY_EN
    assign nxt_valid = v_nxt;
`endif
  end

endmodule

// File: rtl/dsp_elastic_pipe.sv
// Chain of DEPTH elastic slots (registered or bypassed per REG_MASK) with valid/ready flow control.
// Optional occupancy output port enabled by defining DSP_PIPE_OCCUPANCY_EN.
module dsp_elastic_pipe
  import dsp_pipe_pkg::*;
#(
  parameter int               WIDTH    = 18,
  parameter int               DEPTH    = 3,
  parameter logic [DEPTH-1:0] REG_MASK = {DEPTH{1'b1}},
  parameter bit               RST_DATA = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
`ifdef DSP_PIPE_OCCUPANCY_EN
  ,
  output logic [occ_width(DEPTH)-1:0] occupancy
`endif
);

  typedef `DSP_PIPE_BEAT_T(WIDTH) beat_t;

  beat_t chain [DEPTH+1];
  logic  ready [DEPTH+1];
`ifdef DSP_PIPE_OCCUPANCY_EN
  logic  nxt   [DEPTH];
`endif

  assign chain[0]     = beat_t'{valid: in_valid, data: in_data};
  assign ready[DEPTH] = out_ready;

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    dsp_pipe_slot #(
      .beat_t   (beat_t),
      .BYPASS   (~REG_MASK[i]),
      .RST_DATA (RST_DATA)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .ce       (ce),
      .flush    (flush),
      .up_beat  (chain[i]),
      .up_ready (ready[i]),
      .dn_beat  (chain[i+1]),
      .dn_ready (ready[i+1])
`ifdef DSP_PIPE_OCCUPANCY_EN
      ,
      .nxt_valid(nxt[i])
`endif
    );
  end

  assign in_ready  = ready[0] & ce & ~flush;
  assign out_valid = chain[DEPTH].valid;
  assign out_data  = chain[DEPTH].data;

`ifdef DSP_PIPE_OCCUPANCY_EN
  localparam int OCC_W = occ_width(DEPTH);

  logic [MAX_DEPTH-1:0] nxt_vec;

  always_comb begin
    nxt_vec = '0;
    for (int i = 0; i < DEPTH; i++) nxt_vec[i] = nxt[i];
  end

  // Counts the valid bits each slot will hold after this edge, so it tracks v[] exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     occupancy <= '0;
    else if (ce) occupancy <= OCC_W'(popcount(nxt_vec));
  end
`endif

endmodule
